// File: rtl/rot_tlul_host.sv
// TL-UL 32-bit host: turns a valid/ready register command stream into A-channel
// requests, and returns D-channel responses in order through a registered queue.
module rot_tlul_host #(
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [3:0]  SourcePrefix   = 4'h0,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_we_o,
    output logic        rsp_err_o,
    output logic        a_valid_o,
    input  logic        a_ready_i,
    output logic [2:0]  a_opcode_o,
    output logic [2:0]  a_param_o,
    output logic [1:0]  a_size_o,
    output logic [7:0]  a_source_o,
    output logic [31:0] a_address_o,
    output logic [3:0]  a_mask_o,
    output logic [31:0] a_data_o,
    input  logic        d_valid_i,
    output logic        d_ready_o,
    input  logic [2:0]  d_opcode_i,
    input  logic [2:0]  d_param_i,
    input  logic [1:0]  d_size_i,
    input  logic [7:0]  d_source_i,
    input  logic        d_sink_i,
    input  logic [31:0] d_data_i,
    input  logic        d_error_i,
    output logic [4:0]  inflight_o,
    output logic        order_err_o,
    output logic        timeout_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [4:0]      MaxOut     = 5'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastIdx    = PtrW'(MaxOutstanding - 1);
    localparam logic [31:0]     TimeoutLim = 32'(TimeoutCycles);

    typedef enum logic [2:0] {
        OpPutFull    = 3'd0,
        OpPutPartial = 3'd1,
        OpGet        = 3'd4
    } a_op_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        we;
        logic        err;
    } rsp_t;

    logic            rst_done_q;
    logic            a_valid_q, a_valid_d;
    a_op_e           a_opcode_q, a_opcode_d;
    logic [7:0]      a_source_q, a_source_d;
    logic [31:0]     a_address_q, a_address_d;
    logic [3:0]      a_mask_q, a_mask_d;
    logic [31:0]     a_data_q, a_data_d;
    logic [3:0]      seq_q, seq_d, exp_seq_q, exp_seq_d;
    logic [4:0]      inflight_q, inflight_d, issued_q, issued_d, fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]     timer_q, timer_d;
    logic            order_err_q, order_err_d, timeout_q, timeout_d;
    rsp_t            fifo_q [MaxOutstanding];
    rsp_t            fifo_d [MaxOutstanding];

    logic accept, a_fire, d_fire, orphan, push, pop, src_ok;
    logic unused_d_fields;

    assign unused_d_fields = ^{d_param_i, d_size_i, d_sink_i};

    // rst_done_q keeps the command port closed while reset is asserted.
    assign req_ready_o = rst_done_q && (inflight_q < MaxOut) && (!a_valid_q || a_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign a_fire      = a_valid_q && a_ready_i;
    assign d_ready_o   = (fifo_cnt_q != MaxOut);
    assign d_fire      = d_valid_i && d_ready_o;
    assign orphan      = d_fire && (issued_q == 5'd0);
    assign push        = d_fire && !orphan;
    assign rsp_valid_o = (fifo_cnt_q != 5'd0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign src_ok      = (d_source_i == {SourcePrefix, exp_seq_q});

    always_comb begin
        a_valid_d   = a_valid_q;
        a_opcode_d  = a_opcode_q;
        a_source_d  = a_source_q;
        a_address_d = a_address_q;
        a_mask_d    = a_mask_q;
        a_data_d    = a_data_q;
        seq_d       = seq_q;
        if (accept) begin
            a_valid_d   = 1'b1;
            a_source_d  = {SourcePrefix, seq_q};
            a_address_d = req_addr_i;
            seq_d       = seq_q + 4'd1;
            if (!req_we_i) begin
                a_opcode_d = OpGet;
                a_mask_d   = 4'hF;
                a_data_d   = 32'd0;
            end else if (req_be_i == 4'hF) begin
                a_opcode_d = OpPutFull;
                a_mask_d   = 4'hF;
                a_data_d   = req_wdata_i;
            end else begin
                a_opcode_d = OpPutPartial;
                a_mask_d   = req_be_i;
                a_data_d   = req_wdata_i;
            end
        end else if (a_fire) begin
            a_valid_d = 1'b0;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !pop) begin
            inflight_d = inflight_q + 5'd1;
        end else if (!accept && pop) begin
            inflight_d = inflight_q - 5'd1;
        end

        issued_d = issued_q;
        if (a_fire && !push) begin
            issued_d = issued_q + 5'd1;
        end else if (!a_fire && push) begin
            issued_d = issued_q - 5'd1;
        end

        exp_seq_d   = push ? exp_seq_q + 4'd1 : exp_seq_q;
        order_err_d = order_err_q || orphan || (push && !src_ok);

        // The timer saturates at the limit; the stuck request is never retired.
        timer_d = timer_q;
        if ((issued_q == 5'd0) || d_fire) begin
            timer_d = 32'd0;
        end else if (timer_q != TimeoutLim) begin
            timer_d = timer_q + 32'd1;
        end
        timeout_d = timeout_q || ((TimeoutLim != 32'd0) && (timer_d == TimeoutLim));
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q].rdata = (d_opcode_i == 3'd0) ? 32'd0 : d_data_i;
            fifo_d[wr_ptr_q].we    = (d_opcode_i == 3'd0);
            fifo_d[wr_ptr_q].err   = d_error_i || !src_ok;
            wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
        end
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 5'd1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_done_q  <= 1'b0;
            a_valid_q   <= 1'b0;
            a_opcode_q  <= OpPutFull;
            a_source_q  <= 8'd0;
            a_address_q <= 32'd0;
            a_mask_q    <= 4'd0;
            a_data_q    <= 32'd0;
            seq_q       <= 4'd0;
            exp_seq_q   <= 4'd0;
            inflight_q  <= 5'd0;
            issued_q    <= 5'd0;
            fifo_cnt_q  <= 5'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            timer_q     <= 32'd0;
            order_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rst_done_q  <= 1'b1;
            a_valid_q   <= a_valid_d;
            a_opcode_q  <= a_opcode_d;
            a_source_q  <= a_source_d;
            a_address_q <= a_address_d;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
            seq_q       <= seq_d;
            exp_seq_q   <= exp_seq_d;
            inflight_q  <= inflight_d;
            issued_q    <= issued_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            timer_q     <= timer_d;
            order_err_q <= order_err_d;
            timeout_q   <= timeout_d;
            fifo_q      <= fifo_d;
        end
    end

    assign a_valid_o   = a_valid_q;
    assign a_opcode_o  = a_opcode_q;
    assign a_param_o   = 3'd0;
    assign a_size_o    = a_valid_q ? 2'd2 : 2'd0;
    assign a_source_o  = a_source_q;
    assign a_address_o = a_address_q;
    assign a_mask_o    = a_mask_q;
    assign a_data_o    = a_data_q;
    assign rsp_rdata_o = fifo_q[rd_ptr_q].rdata;
    assign rsp_we_o    = fifo_q[rd_ptr_q].we;
    assign rsp_err_o   = fifo_q[rd_ptr_q].err;
    assign inflight_o  = inflight_q;
    assign order_err_o = order_err_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rot_tlul_host.sv
// Directed bench for rot_tlul_host: a vector table of single transactions plus
// hand-written sequences for backpressure, source order, timeout and reset.
module tb_rot_tlul_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_we_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        a_valid_o, a_ready_i;
    logic [2:0]  a_opcode_o, a_param_o;
    logic [1:0]  a_size_o;
    logic [7:0]  a_source_o;
    logic [31:0] a_address_o, a_data_o;
    logic [3:0]  a_mask_o;
    logic        d_valid_i, d_ready_o, d_sink_i, d_error_i;
    logic [2:0]  d_opcode_i, d_param_i;
    logic [1:0]  d_size_i;
    logic [7:0]  d_source_i;
    logic [31:0] d_data_i;
    logic [4:0]  inflight_o;
    logic        order_err_o, timeout_o;

    int tests_run = 0;
    int tests_failed = 0;
    int a_beats = 0;

    rot_tlul_host #(
        .MaxOutstanding(4),
        .SourcePrefix  (4'h0),
        .TimeoutCycles (8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
        .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_opcode_o(a_opcode_o),
        .a_param_o(a_param_o), .a_size_o(a_size_o), .a_source_o(a_source_o),
        .a_address_o(a_address_o), .a_mask_o(a_mask_o), .a_data_o(a_data_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i),
        .d_param_i(d_param_i), .d_size_i(d_size_i), .d_source_i(d_source_i),
        .d_sink_i(d_sink_i), .d_data_i(d_data_i), .d_error_i(d_error_i),
        .inflight_o(inflight_o), .order_err_o(order_err_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_valid_o && a_ready_i) a_beats++;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  d_opcode;
        logic [31:0] d_data;
        logic        d_err;
        logic [2:0]  exp_opcode;
        logic [3:0]  exp_mask;
        logic [31:0] exp_adata;
        logic [31:0] exp_rdata;
        logic        exp_rsp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_be_i    = be;
        req_wdata_i = wdata;
    endtask

    task automatic driveD(input logic [2:0] opcode, input logic [7:0] source,
                          input logic [31:0] data, input logic err);
        d_valid_i  = 1'b1;
        d_opcode_i = opcode;
        d_source_i = source;
        d_data_i   = data;
        d_error_i  = err;
    endtask

    task automatic popOne();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        int hs_before;

        vecs[0] = '{we:1'b0, addr:32'h0000_1000, be:4'h0, wdata:32'h0, d_opcode:3'd1,
                    d_data:32'hDEAD_BEEF, d_err:1'b0, exp_opcode:3'd4, exp_mask:4'hF,
                    exp_adata:32'h0, exp_rdata:32'hDEAD_BEEF, exp_rsp_err:1'b0};
        vecs[1] = '{we:1'b1, addr:32'h0000_2004, be:4'hF, wdata:32'h1234_5678, d_opcode:3'd0,
                    d_data:32'hAAAA_5555, d_err:1'b0, exp_opcode:3'd0, exp_mask:4'hF,
                    exp_adata:32'h1234_5678, exp_rdata:32'h0, exp_rsp_err:1'b0};
        vecs[2] = '{we:1'b1, addr:32'h0000_2004, be:4'h3, wdata:32'h1234_5678, d_opcode:3'd0,
                    d_data:32'h0, d_err:1'b0, exp_opcode:3'd1, exp_mask:4'h3,
                    exp_adata:32'h1234_5678, exp_rdata:32'h0, exp_rsp_err:1'b0};
        vecs[3] = '{we:1'b1, addr:32'h0000_3003, be:4'h0, wdata:32'hCAFE_F00D, d_opcode:3'd0,
                    d_data:32'h0000_0099, d_err:1'b0, exp_opcode:3'd1, exp_mask:4'h0,
                    exp_adata:32'hCAFE_F00D, exp_rdata:32'h0, exp_rsp_err:1'b0};
        vecs[4] = '{we:1'b0, addr:32'h0000_0040, be:4'h0, wdata:32'h0, d_opcode:3'd1,
                    d_data:32'h0000_0011, d_err:1'b1, exp_opcode:3'd4, exp_mask:4'hF,
                    exp_adata:32'h0, exp_rdata:32'h0000_0011, exp_rsp_err:1'b1};
        vecs[5] = '{we:1'b0, addr:32'h0000_0044, be:4'h5, wdata:32'hFFFF_FFFF, d_opcode:3'd1,
                    d_data:32'h0BAD_F00D, d_err:1'b0, exp_opcode:3'd4, exp_mask:4'hF,
                    exp_adata:32'h0, exp_rdata:32'h0BAD_F00D, exp_rsp_err:1'b0};

        rst_n = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_be_i = '0; req_wdata_i = '0;
        rsp_ready_i = 1'b0; a_ready_i = 1'b1;
        d_valid_i = 1'b0; d_opcode_i = '0; d_param_i = '0; d_size_i = '0; d_source_i = '0;
        d_sink_i = 1'b0; d_data_i = '0; d_error_i = 1'b0;
        step();
        step();
        checkOutput("rst_a_valid",   64'(a_valid_o), 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("rst_d_ready",   64'(d_ready_o), 64'd1);
        checkOutput("rst_inflight",  64'(inflight_o), 64'd0);
        checkOutput("rst_order_err", 64'(order_err_o), 64'd0);
        checkOutput("rst_timeout",   64'(timeout_o), 64'd0);
        checkOutput("rst_rdata",     64'(rsp_rdata_o), 64'd0);
        rst_n = 1'b1;
        step();
        step();

        // Table of single transactions, sources 0..5 in order.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
            #1;
            checkOutput("vec_req_ready", 64'(req_ready_o), 64'd1);
            step();
            req_valid_i = 1'b0;
            #1;
            checkOutput("vec_a_valid",   64'(a_valid_o), 64'd1);
            checkOutput("vec_a_opcode",  64'(a_opcode_o), 64'(vecs[i].exp_opcode));
            checkOutput("vec_a_mask",    64'(a_mask_o), 64'(vecs[i].exp_mask));
            checkOutput("vec_a_data",    64'(a_data_o), 64'(vecs[i].exp_adata));
            checkOutput("vec_a_address", 64'(a_address_o), 64'(vecs[i].addr));
            checkOutput("vec_a_source",  64'(a_source_o), 64'(i));
            checkOutput("vec_a_size",    64'(a_size_o), 64'd2);
            checkOutput("vec_a_param",   64'(a_param_o), 64'd0);
            checkOutput("vec_inflight",  64'(inflight_o), 64'd1);
            step();
            checkOutput("vec_a_taken", 64'(a_valid_o), 64'd0);
            driveD(vecs[i].d_opcode, 8'(i), vecs[i].d_data, vecs[i].d_err);
            #1;
            checkOutput("vec_d_ready", 64'(d_ready_o), 64'd1);
            step();
            d_valid_i = 1'b0;
            checkOutput("vec_rsp_valid", 64'(rsp_valid_o), 64'd1);
            checkOutput("vec_rsp_rdata", 64'(rsp_rdata_o), 64'(vecs[i].exp_rdata));
            checkOutput("vec_rsp_we",    64'(rsp_we_o), 64'(vecs[i].we));
            checkOutput("vec_rsp_err",   64'(rsp_err_o), 64'(vecs[i].exp_rsp_err));
            popOne();
            checkOutput("vec_rsp_drained", 64'(rsp_valid_o), 64'd0);
            checkOutput("vec_inflight0",   64'(inflight_o), 64'd0);
        end

        // Four back-to-back reads fill the window; sources 6..9.
        applyStimulus(1'b0, 32'h0000_0100, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("bp_req_ready", 64'(req_ready_o), 64'd1);
            step();
        end
        checkOutput("bp_full_ready", 64'(req_ready_o), 64'd0);
        checkOutput("bp_inflight4",  64'(inflight_o), 64'd4);
        req_valid_i = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            driveD(3'd1, 8'(6 + k), 32'h0000_00A0 + 32'(k), 1'b0);
            step();
        end
        d_valid_i = 1'b0;
        #1;
        checkOutput("bp_fifo_full_d_ready", 64'(d_ready_o), 64'd0);
        checkOutput("bp_order_err", 64'(order_err_o), 64'd0);
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_rsp_rdata", 64'(rsp_rdata_o), 64'h0000_00A0 + 64'(k));
            step();
            if (k == 0) begin
                checkOutput("bp_inflight3",  64'(inflight_o), 64'd3);
                checkOutput("bp_ready_back", 64'(req_ready_o), 64'd1);
            end
        end
        rsp_ready_i = 1'b0;
        checkOutput("bp_drained", 64'(inflight_o), 64'd0);

        // A channel held off for 5 cycles on a partial write; source 0x0A.
        a_ready_i = 1'b0;
        applyStimulus(1'b1, 32'h0000_5008, 4'hC, 32'h0BAD_CAFE);
        #1;
        checkOutput("hold_accept", 64'(req_ready_o), 64'd1);
        step();
        req_valid_i = 1'b0;
        hs_before = a_beats;
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_hdr",  {35'd0, a_valid_o, a_opcode_o, a_mask_o, a_source_o, a_size_o},
                        {35'd0, 1'b1, 3'd1, 4'hC, 8'h0A, 2'd2});
            checkOutput("hold_addr", 64'(a_address_o), 64'h0000_5008);
            checkOutput("hold_data", 64'(a_data_o), 64'h0BAD_CAFE);
            step();
        end
        checkOutput("hold_req_ready", 64'(req_ready_o), 64'd0);
        a_ready_i = 1'b1;
        step();
        checkOutput("hold_a_done",  64'(a_valid_o), 64'd0);
        checkOutput("hold_one_beat", 64'(a_beats - hs_before), 64'd1);
        driveD(3'd0, 8'h0A, 32'hFFFF_FFFF, 1'b0);
        step();
        d_valid_i = 1'b0;
        checkOutput("hold_rsp_we",    64'(rsp_we_o), 64'd1);
        checkOutput("hold_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        checkOutput("hold_rsp_err",   64'(rsp_err_o), 64'd0);
        popOne();

        // Device answers source 0x0C while 0x0B is expected.
        checkOutput("ord_pre", 64'(order_err_o), 64'd0);
        applyStimulus(1'b0, 32'h0000_6000, 4'h0, 32'h0);
        step();
        req_valid_i = 1'b0;
        step();
        driveD(3'd1, 8'h0C, 32'h5555_AAAA, 1'b0);
        step();
        d_valid_i = 1'b0;
        checkOutput("ord_rsp_valid", 64'(rsp_valid_o), 64'd1);
        checkOutput("ord_rsp_err",   64'(rsp_err_o), 64'd1);
        checkOutput("ord_rsp_rdata", 64'(rsp_rdata_o), 64'h5555_AAAA);
        checkOutput("ord_sticky",    64'(order_err_o), 64'd1);
        popOne();

        // Read with no D beat: timeout after 8 outstanding cycles, then reset.
        checkOutput("to_pre", 64'(timeout_o), 64'd0);
        applyStimulus(1'b0, 32'h0000_7000, 4'h0, 32'h0);
        step();
        req_valid_i = 1'b0;
        step();
        for (int c = 0; c < 7; c++) step();
        checkOutput("to_not_yet", 64'(timeout_o), 64'd0);
        step();
        checkOutput("to_fired", 64'(timeout_o), 64'd1);
        step();
        checkOutput("to_sticky", 64'(timeout_o), 64'd1);

        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_a_valid",   64'(a_valid_o), 64'd0);
        checkOutput("mid_rst_a_source",  64'(a_source_o), 64'd0);
        checkOutput("mid_rst_a_address", 64'(a_address_o), 64'd0);
        checkOutput("mid_rst_req_ready", 64'(req_ready_o), 64'd0);
        checkOutput("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("mid_rst_inflight",  64'(inflight_o), 64'd0);
        checkOutput("mid_rst_order_err", 64'(order_err_o), 64'd0);
        checkOutput("mid_rst_timeout",   64'(timeout_o), 64'd0);
        checkOutput("mid_rst_d_ready",   64'(d_ready_o), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        step();

        // Late/unsolicited D beat after reset: dropped, flagged.
        driveD(3'd1, 8'h00, 32'h0000_0077, 1'b0);
        step();
        d_valid_i = 1'b0;
        checkOutput("orphan_no_rsp",   64'(rsp_valid_o), 64'd0);
        checkOutput("orphan_flag",     64'(order_err_o), 64'd1);
        checkOutput("orphan_inflight", 64'(inflight_o), 64'd0);

        applyStimulus(1'b0, 32'h0000_8000, 4'h0, 32'h0);
        #1;
        checkOutput("post_rst_ready", 64'(req_ready_o), 64'd1);
        step();
        req_valid_i = 1'b0;
        checkOutput("post_rst_source", 64'(a_source_o), 64'd0);
        step();
        driveD(3'd1, 8'h00, 32'h0000_1234, 1'b0);
        step();
        d_valid_i = 1'b0;
        checkOutput("post_rst_rsp_valid", 64'(rsp_valid_o), 64'd1);
        checkOutput("post_rst_rdata",     64'(rsp_rdata_o), 64'h0000_1234);
        popOne();
        checkOutput("post_rst_inflight", 64'(inflight_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
